vga_line_fetcher: RTL and testbench
===================================

# vga_line_fetcher

Ping-pong line-buffer controller placed between a framebuffer memory port and the VGA timing generator. While the generator displays line r from one bank, this block fetches line r+1 into the other bank over a req/ack memory handshake. At each line start it swaps banks and streams pixels indexed by `column`, one cycle behind the timing outputs. It detects and flags fetch underruns, so the conveyor display shows a stale line instead of corrupt data.

## Interface
- `H_PIXELS`, 640: active pixels per line; also the number of words fetched per line.
- `V_PIXELS`, 480: active lines per frame.
- `PIX_W`, 8: bits per pixel (RGB332); also the memory data width.
- `ADDR_W`, 19: memory word address width.
- `FB_BASE`, 0: word address of row 0, column 0.

- `pixel_clk` in 1: pixel clock; the only clock.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: allows new fetch launches.
- `disp_ena` in 1: display enable from the timing generator.
- `column` in 32: horizontal coordinate from the timing generator.
- `row` in 32: vertical coordinate from the timing generator.
- `mem_req` out 1: fetch request; held high for the whole line fetch.
- `mem_addr` out ADDR_W: address of the current beat.
- `mem_ack` in 1: beat accepted; `mem_rdata` is valid in this cycle.
- `mem_rdata` in PIX_W: pixel word returned by memory.
- `pix_data` out PIX_W: pixel to the DAC; 0 when blank.
- `pix_valid` out 1: `disp_ena` delayed by 1 cycle.
- `fetch_busy` out 1: high while in state FETCH.
- `underrun` out 1: sticky; set when a line was not ready in time. Cleared only by reset.

## Operation
- **Edge detect:** `de_q` holds the previous `disp_ena`.
  - Rise = `disp_ena & ~de_q`.
  - Fall = `~disp_ena & de_q`.
- **Launch events** (only while `enable`=1):
  - Rise with `row` < V_PIXELS-1: fetch row+1.
  - Fall with `row` = V_PIXELS-1: fetch row 0 during vertical blanking.
- **Line address:** `line_addr` is loaded with FB_BASE for a row-0 fetch and incremented by H_PIXELS for every other fetch. No multiplier.
- **FSM states:**
  - IDLE: on launch, go to FETCH with `wr_sel` = ~`ready_sel`, `wr_idx` = 0, `mem_addr` = line address, `mem_req` = 1.
  - FETCH, on each cycle with `mem_req & mem_ack`: write `mem_rdata` to bank[`wr_sel`][`wr_idx`], then increment `wr_idx` and `mem_addr`.
  - FETCH, after beat H_PIXELS-1: set `mem_req`=0, `ready_sel` <= `wr_sel`, `have_line` <= 1, go to IDLE.
  - FETCH, on a launch event: abort, set `underrun`, restart FETCH for the new line. An ack in that same cycle is discarded.
- **Bank swap:** on Rise, the read uses `ready_sel` in that same cycle and `disp_sel` <= `ready_sel`.
  - If the previous fetch has not completed, `ready_sel` is unchanged and the old bank is re-displayed. A Rise while in FETCH also sets `underrun`.
- **Pixel output:** `pix_data` <= bank[sel][`column`] when `disp_ena` & `have_line`, else 0.
  - sel is `ready_sel` on the Rise cycle and `disp_sel` otherwise.
  - Only `column[$clog2(H_PIXELS)-1:0]` is used.
- **Enable:** dropping `enable` lets the current fetch finish; no new launches occur. Display continues from the existing banks.

## Timing
- **Reset values:**
  - Outputs: `mem_req`=0, `mem_addr`=FB_BASE, `pix_data`=0, `pix_valid`=0, `fetch_busy`=0, `underrun`=0.
  - Internal: `disp_sel`=0, `ready_sel`=0, `have_line`=0, FSM in IDLE.
- **Pixel latency:** exactly 1 clock from the (`column`, `disp_ena`) sample to `pix_data`/`pix_valid`.
- **Memory handshake:**
  - `mem_addr` is stable while `mem_req`=1 and `mem_ack`=0.
  - Back-to-back acks give 1 beat per clock.
  - `mem_req` drops in the cycle after the last ack.
- **Fetch start:** `mem_req` rises 1 clock after the launch event.
- **Fetch budget:** the fetch for row r+1 must finish before the next Rise.
  - With a zero-wait memory, a fetch takes H_PIXELS+1 clocks, which fits within one 800-clock line period.
- **Reset mid-fetch:** everything returns to reset values in the next cycle and `mem_req` drops immediately. Memory must tolerate a withdrawn request.
- **Write/read collision:** a write and a read never target the same bank, because `wr_sel` ≠ `disp_sel` is guaranteed while in FETCH.

## Structure
- **Shared package `vga_pkg`:**
  - Fetch state enum {IDLE, FETCH}.
  - Default 640x480 timing constants.
  - Pixel type of width PIX_W.
- **Sub-module `vga_line_buffer`:** 2-bank RAM, 1 write port and 1 registered read port, with bank-select address bit. It infers block RAM.
- **Controller in this module:** FSM, edge detect, line address and sticky flag.

## Test plan
Scenarios 1-4 use H_PIXELS=8, V_PIXELS=4, FB_BASE=16, timing generator instance with porches 2/2/2, zero-wait memory returning rdata = addr[7:0].
1. **Reset then first frame:** after the first row-0 fetch, `pix_data` on row 0 = 16..23 and on row 1 = 24..31, each 1 cycle after `column`.
2. **Steady frames:** over 3 frames, row 3 shows 40..47, the next row 0 shows 16..23 again, and `underrun` stays 0.
3. **Slow memory** (`mem_ack` every 3rd cycle, so a fetch exceeds the line period) -> `underrun`=1 at the first Rise and the previous line repeats on screen.
4. **`mem_ack` and a launch in the same cycle** -> that beat is not written, `mem_addr` reloads to the new line address, `underrun`=1.
5. **Reset asserted mid-FETCH at beat 3** -> next cycle `mem_req`=0, `mem_addr`=16, `fetch_busy`=0, `pix_data`=0 until a line completes.
6. **`enable`=0 during FETCH** -> the fetch completes (8 acks), then no further `mem_req`. `pix_valid` keeps tracking `disp_ena`.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel path: fetch FSM states, default
// 640x480 geometry and the RGB332 pixel type.
package vga_pkg;
  localparam int H_PIXELS_DEF = 640;
  localparam int V_PIXELS_DEF = 480;
  localparam int PIX_W_DEF    = 8;
  localparam int ADDR_W_DEF   = 19;

  typedef enum logic {IDLE, FETCH} fetch_state_t;

  typedef logic [PIX_W_DEF-1:0] pixel_t;
endpackage

// File: rtl/vga_line_buffer.sv
// Two-bank line RAM with one write port and one registered read port.
// The bank select is the address MSB, so the array maps onto a single block RAM.
module vga_line_buffer
  import vga_pkg::*;
#(
  parameter  int DEPTH = H_PIXELS_DEF,
  parameter  int PIX_W = PIX_W_DEF,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             pixel_clk,
  input  logic             wr_en,
  input  logic             wr_sel,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             rd_sel,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [PIX_W-1:0] rd_data
);
  logic [PIX_W-1:0] ram [2**(IDX_W+1)];

  always_ff @(posedge pixel_clk) begin
    if (wr_en) ram[{wr_sel, wr_idx}] <= wr_data;
    rd_data <= ram[{rd_sel, rd_idx}];
  end
endmodule

// File: rtl/vga_line_fetcher.sv
// Ping-pong line fetcher: streams the current line from one bank while the
// next line is fetched into the other bank, and flags lines that arrive late.
module vga_line_fetcher
  import vga_pkg::*;
#(
  parameter int H_PIXELS = H_PIXELS_DEF,
  parameter int V_PIXELS = V_PIXELS_DEF,
  parameter int PIX_W    = PIX_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int FB_BASE  = 0
) (
  input  logic              pixel_clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              disp_ena,
  input  logic [31:0]       column,
  input  logic [31:0]       row,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  output logic              fetch_busy,
  output logic              underrun
);
  localparam int                IDX_W     = $clog2(H_PIXELS);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(FB_BASE);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_PIXELS);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(H_PIXELS - 1);
  localparam logic [31:0]       LAST_ROW  = 32'(V_PIXELS - 1);

  fetch_state_t      state_q, state_d;
  logic              de_q, rise, fall, launch, launch_row0;
  logic              mem_req_d, underrun_d, wr_en, rd_sel, show_q;
  logic [ADDR_W-1:0] mem_addr_d, line_addr_q, line_addr_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic              wr_sel_q, wr_sel_d, ready_sel_q, ready_sel_d, disp_sel_q;
  logic              have_line_q, have_line_d;
  logic [PIX_W-1:0]  rd_data;
  logic              unused_col_hi;

  assign rise        = disp_ena & ~de_q;
  assign fall        = ~disp_ena & de_q;
  assign launch_row0 = enable & fall & (row == LAST_ROW);
  assign launch      = launch_row0 | (enable & rise & (row < LAST_ROW));
  assign rd_sel      = rise ? ready_sel_q : disp_sel_q;
  assign fetch_busy  = (state_q == FETCH);
  assign pix_data    = show_q ? rd_data : '0;
  assign unused_col_hi = ^column[31:IDX_W];

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req;
    mem_addr_d  = mem_addr;
    line_addr_d = line_addr_q;
    wr_idx_d    = wr_idx_q;
    wr_sel_d    = wr_sel_q;
    ready_sel_d = ready_sel_q;
    have_line_d = have_line_q;
    underrun_d  = underrun;
    wr_en       = 1'b0;
    // A new line wanted (or displayed) while the last one is still arriving.
    if (state_q == FETCH && (rise || launch)) underrun_d = 1'b1;
    if (launch) begin
      // Row addresses advance by a line per fetch; only row 0 reloads the base.
      line_addr_d = launch_row0 ? BASE : line_addr_q + LINE_STEP;
      state_d     = FETCH;
      mem_req_d   = 1'b1;
      mem_addr_d  = line_addr_d;
      wr_idx_d    = '0;
      wr_sel_d    = ~ready_sel_q;
    end else if (state_q == FETCH && mem_req && mem_ack) begin
      wr_en      = 1'b1;
      mem_addr_d = mem_addr + 1'b1;
      wr_idx_d   = wr_idx_q + 1'b1;
      if (wr_idx_q == LAST_IDX) begin
        state_d     = IDLE;
        mem_req_d   = 1'b0;
        ready_sel_d = wr_sel_q;
        have_line_d = 1'b1;
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      de_q        <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= BASE;
      line_addr_q <= BASE;
      wr_idx_q    <= '0;
      wr_sel_q    <= 1'b0;
      ready_sel_q <= 1'b0;
      disp_sel_q  <= 1'b0;
      have_line_q <= 1'b0;
      underrun    <= 1'b0;
      pix_valid   <= 1'b0;
      show_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      de_q        <= disp_ena;
      mem_req     <= mem_req_d;
      mem_addr    <= mem_addr_d;
      line_addr_q <= line_addr_d;
      wr_idx_q    <= wr_idx_d;
      wr_sel_q    <= wr_sel_d;
      ready_sel_q <= ready_sel_d;
      have_line_q <= have_line_d;
      underrun    <= underrun_d;
      pix_valid   <= disp_ena;
      show_q      <= disp_ena & have_line_q;
      if (rise) disp_sel_q <= ready_sel_q;
    end
  end

  vga_line_buffer #(.DEPTH(H_PIXELS), .PIX_W(PIX_W)) u_buf (
    .pixel_clk (pixel_clk),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel_q),
    .wr_idx    (wr_idx_q),
    .wr_data   (mem_rdata),
    .rd_sel    (rd_sel),
    .rd_idx    (column[IDX_W-1:0]),
    .rd_data   (rd_data)
  );
endmodule

// File: tb/tb_vga_line_fetcher.sv
// Bench for vga_line_fetcher on an 8x4 screen with 2/2/2 porches and a memory
// that returns the low address byte; a line-level model predicts every output.
module tb_vga_line_fetcher;
  import vga_pkg::*;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int FB = 16;
  localparam int AW = 19;
  localparam int HT = H + 6;
  localparam int VT = V + 6;

  logic          pixel_clk = 1'b0;
  logic          reset     = 1'b1;
  logic          enable    = 1'b1;
  logic          disp_ena  = 1'b0;
  logic [31:0]   column    = '0;
  logic [31:0]   row       = '0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack   = 1'b0;
  pixel_t        mem_rdata = '0;
  pixel_t        pix_data;
  logic          pix_valid, fetch_busy, underrun;

  int h = 0, v = 6, cyc = 0, ack_mode = 0;
  int n_chk = 0, n_pass = 0;

  always #5 pixel_clk = ~pixel_clk;

  vga_line_fetcher #(.H_PIXELS(H), .V_PIXELS(V), .PIX_W(8), .ADDR_W(AW), .FB_BASE(FB)) dut (
    .pixel_clk  (pixel_clk),
    .reset      (reset),
    .enable     (enable),
    .disp_ena   (disp_ena),
    .column     (column),
    .row        (row),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .fetch_busy (fetch_busy),
    .underrun   (underrun)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int pix_of(input int r, input int c);
    return (FB + r * H + c) % 256;
  endfunction

  // One clock: advance the timing generator and the memory, #1 after the edge.
  task automatic step();
    logic de_old;
    @(posedge pixel_clk);
    #1;
    cyc++;
    de_old = disp_ena;
    if (h == HT - 1) begin
      h = 0;
      v = (v == VT - 1) ? 0 : v + 1;
    end else h++;
    column   = 32'(h);
    row      = 32'(v);
    disp_ena = (h < H) && (v < V);
    case (ack_mode)
      0:       mem_ack = mem_req;
      1:       mem_ack = mem_req && (cyc % 3 == 0);
      default: mem_ack = mem_req && disp_ena && !de_old;
    endcase
    mem_rdata = mem_addr[7:0];
  endtask

  task automatic run_to(input int r, input int c);
    int n;
    n = 0;
    do begin
      step();
      n++;
      if (n > 2 * HT * VT) begin
        n_chk++;
        $display("FAIL run_to: timed out waiting for row %0d col %0d", r, c);
        return;
      end
    end while (!(v == r && h == c));
  endtask

  // Line-level model: which row sits in the ready buffer, which row is on
  // screen, and how far the current fetch has got.
  int m_ready, m_disp, m_tgt, m_beats, e_pix;
  bit m_fetch, m_have, m_under, m_de, m_init, e_pix_known, e_valid;

  always @(posedge pixel_clk) begin
    bit rise, fall, launch;
    if (reset) begin
      m_init = 1; m_fetch = 0; m_have = 0; m_under = 0; m_de = 0;
      m_ready = -1; m_disp = -1; m_tgt = 0; m_beats = 0;
      e_pix = 0; e_pix_known = 1; e_valid = 0;
    end else begin
      rise   = disp_ena && !m_de;
      fall   = !disp_ena && m_de;
      launch = enable && ((rise && int'(row) < V - 1) || (fall && int'(row) == V - 1));
      if (rise) begin
        if (m_fetch) m_under = 1;
        m_disp = m_ready;
      end
      e_valid = disp_ena;
      if (disp_ena && m_have) begin
        e_pix_known = (m_disp >= 0);
        e_pix       = (m_disp >= 0) ? pix_of(m_disp, int'(column) % H) : 0;
      end else begin
        e_pix_known = 1;
        e_pix       = 0;
      end
      if (launch) begin
        if (m_fetch) m_under = 1;
        m_fetch = 1;
        m_beats = 0;
        m_tgt   = rise ? int'(row) + 1 : 0;
      end else if (m_fetch && mem_ack) begin
        m_beats++;
        if (m_beats == H) begin
          m_fetch = 0;
          m_ready = m_tgt;
          m_have  = 1;
        end
      end
      m_de = disp_ena;
    end
  end

  always @(negedge pixel_clk) begin
    if (m_init) begin
      chk("pix_valid", int'(pix_valid), int'(e_valid));
      if (e_pix_known) chk("pix_data", int'(pix_data), e_pix);
      chk("mem_req", int'(mem_req), int'(m_fetch));
      chk("fetch_busy", int'(fetch_busy), int'(m_fetch));
      chk("underrun", int'(underrun), int'(m_under));
      if (m_fetch) chk("mem_addr", int'(mem_addr), FB + m_tgt * H + m_beats);
    end
  end

  initial begin
    int busy_cnt;
    column = 32'(h); row = 32'(v);
    repeat (3) step();
    chk("reset mem_req", int'(mem_req), 0);
    chk("reset mem_addr", int'(mem_addr), 16);
    chk("reset pix_data", int'(pix_data), 0);
    chk("reset pix_valid", int'(pix_valid), 0);
    chk("reset fetch_busy", int'(fetch_busy), 0);
    chk("reset underrun", int'(underrun), 0);
    reset = 1'b0;

    // First frame: row 0 has no line yet, row 1 was fetched during row 0.
    run_to(0, 3); step(); chk("s1 f1 row0 blank", int'(pix_data), 0);
    run_to(1, 5); step(); chk("s1 f1 row1 col5", int'(pix_data), 29);
    run_to(5, 0);
    run_to(0, 3); step(); chk("s1 row0 col3", int'(pix_data), 19);
    run_to(1, 0); step(); chk("s1 row1 col0", int'(pix_data), 24);
    run_to(3, 7); step(); chk("s2 row3 col7", int'(pix_data), 47);
    run_to(0, 1); step(); chk("s2 next row0 col1", int'(pix_data), 17);
    run_to(5, 0);
    chk("s2 no underrun", int'(underrun), 0);

    // Slow memory: the row-1 fetch cannot finish, row 0 repeats.
    ack_mode = 1;
    run_to(1, 2); step();
    chk("s3 underrun", int'(underrun), 1);
    chk("s3 repeat row0", int'(pix_data), 18);
    run_to(5, 0);
    run_to(2, 0);
    run_to(5, 0);

    // Ack coinciding with a launch: beat dropped, address reloads.
    reset = 1'b1; step(); step(); reset = 1'b0;
    ack_mode = 2;
    run_to(0, 0); step();
    run_to(1, 0);
    chk("s4 stalled addr", int'(mem_addr), 24);
    step();
    chk("s4 reload addr", int'(mem_addr), 32);
    chk("s4 underrun", int'(underrun), 1);
    chk("s4 mem_req", int'(mem_req), 1);
    run_to(5, 0);

    // Reset in the middle of a fetch.
    ack_mode = 0;
    reset = 1'b1; step(); reset = 1'b0;
    run_to(0, 0);
    repeat (4) step();
    chk("s5 busy before", int'(fetch_busy), 1);
    reset = 1'b1; step();
    chk("s5 mem_req", int'(mem_req), 0);
    chk("s5 mem_addr", int'(mem_addr), 16);
    chk("s5 fetch_busy", int'(fetch_busy), 0);
    chk("s5 pix_data", int'(pix_data), 0);
    run_to(5, 0);
    reset = 1'b0;
    run_to(0, 4); step(); chk("s5 no line", int'(pix_data), 0);

    // Drop enable mid-fetch: the fetch completes, nothing else launches.
    run_to(1, 0);
    repeat (3) step();
    enable = 1'b0;
    chk("s6 busy", int'(fetch_busy), 1);
    run_to(1, 12);
    chk("s6 done", int'(mem_req), 0);
    run_to(3, 3); step(); chk("s6 row3 stale", int'(pix_data), 35);
    busy_cnt = 0;
    repeat (2 * HT * VT) begin
      step();
      if (mem_req) busy_cnt++;
    end
    chk("s6 no mem_req", busy_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
